// File: rtl/regdump_pkg.sv
// Shared types and constants for the register-file dump engine.
// Optional checksum beat is enabled by defining REGDUMP_CHECKSUM_EN.
package regdump_pkg;

    localparam int unsigned REGDUMP_N = 32;
    localparam int unsigned REGDUMP_R = 5;

`ifdef REGDUMP_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_SUM   = 2'd3
    } state_t;
`else
    localparam bit CSUM_EN = 1'b0;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;
`endif

    // Beats per complete dump: every register, plus the checksum beat when enabled.
    function automatic int unsigned beat_count(input int unsigned r);
        return (32'd1 << r) + (CSUM_EN ? 32'd1 : 32'd0);
    endfunction

    localparam int unsigned BEAT_COUNT = beat_count(REGDUMP_R);

endpackage

// File: rtl/regfile_dump_if.sv
// Regfile read-port pair and valid/ready output stream of the dump engine.
// Handshake: a beat transfers on a rising clk edge where out_valid & out_ready; while out_valid & !out_ready the beat fields hold.
interface regfile_dump_if #(
    parameter int N = 32,
    parameter int R = 5
);

    logic [R-1:0] rf_read_addr1;
    logic [R-1:0] rf_read_addr2;
    logic [N-1:0] rf_read_data1;
    logic [N-1:0] rf_read_data2;

    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic [R-1:0] out_addr;
    logic         out_last;

    modport master (
        output rf_read_addr1, rf_read_addr2,
        input  rf_read_data1, rf_read_data2,
        output out_valid, out_data, out_addr, out_last,
        input  out_ready
    );

    modport slave (
        input  rf_read_addr1, rf_read_addr2,
        output rf_read_data1, rf_read_data2,
        input  out_valid, out_data, out_addr, out_last,
        output out_ready
    );

endinterface

// File: rtl/regdump_buf.sv
// Two-entry pair buffer: loads both words of a register pair at once, pops one word at a time.
// A load while the last word pops replaces it; flush empties the buffer.
module regdump_buf #(
    parameter int N = 32,
    parameter int R = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  logic [N-1:0] ld_data0_i,
    input  logic [R-1:0] ld_addr0_i,
    input  logic [N-1:0] ld_data1_i,
    input  logic [R-1:0] ld_addr1_i,
    output logic [1:0]   count_o,
    output logic [N-1:0] head_data_o,
    output logic [R-1:0] head_addr_o
);

    logic [1:0]   cnt_q, cnt_d;
    logic [N-1:0] d0_q, d0_d, d1_q, d1_d;
    logic [R-1:0] a0_q, a0_d, a1_q, a1_d;

    always_comb begin
        cnt_d = cnt_q;
        d0_d  = d0_q;
        a0_d  = a0_q;
        d1_d  = d1_q;
        a1_d  = a1_q;
        if (flush_i) begin
            cnt_d = 2'd0;
        end else if (load_i) begin
            d0_d  = ld_data0_i;
            a0_d  = ld_addr0_i;
            d1_d  = ld_data1_i;
            a1_d  = ld_addr1_i;
            cnt_d = 2'd2;
        end else if (pop_i && (cnt_q != 2'd0)) begin
            d0_d  = d1_q;
            a0_d  = a1_q;
            cnt_d = cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 2'd0;
            d0_q  <= '0;
            a0_q  <= '0;
            d1_q  <= '0;
            a1_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            d0_q  <= d0_d;
            a0_q  <= a0_d;
            d1_q  <= d1_d;
            a1_q  <= a1_d;
        end
    end

    assign count_o     = cnt_q;
    assign head_data_o = d0_q;
    assign head_addr_o = a0_q;

endmodule

// File: rtl/regfile_dump.sv
// Debug read-out engine: fetches register pairs over both regfile read ports and streams them lowest address first.
// Define REGDUMP_CHECKSUM_EN to append an XOR checksum beat after the last register.
module regfile_dump
    import regdump_pkg::*;
#(
    parameter int N = REGDUMP_N,
    parameter int R = REGDUMP_R,
    localparam int unsigned BEATS = (R == int'(REGDUMP_R)) ? BEAT_COUNT : beat_count(R),
    localparam int BW = $clog2(BEATS + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           abort,
    output logic           busy,
    output logic           done,
    output state_t         dbg_state_o,
    output logic [BW-1:0]  dbg_beats_o,
    regfile_dump_if.master bus
);

    localparam int PW = (R > 1) ? R - 1 : 1;
    localparam logic [PW-1:0] P_LAST = PW'((1 << (R - 1)) - 1);

    state_t        state_q, state_d;
    logic [PW-1:0] p_q, p_d;
    logic          done_q, done_d;
    logic [BW-1:0] beats_q, beats_d;

    logic [1:0]    cnt;
    logic [N-1:0]  head_data;
    logic [R-1:0]  head_addr;
    logic [R-1:0]  addr1, addr2;
    logic          buf_nonempty, hs, pop, load, flush, head_is_top, in_sum;

`ifdef REGDUMP_CHECKSUM_EN
    logic [N-1:0]  acc_q, acc_d;
    assign in_sum = (state_q == ST_SUM);
`else
    assign in_sum = 1'b0;
`endif

    // Even/odd addresses of the current pair; parked at 0/1 outside FETCH.
    assign addr1 = (state_q == ST_FETCH) ? R'({p_q, 1'b0}) : '0;
    assign addr2 = addr1 | R'(1);

    assign bus.rf_read_addr1 = addr1;
    assign bus.rf_read_addr2 = addr2;

    assign buf_nonempty = (cnt != 2'd0);
    assign head_is_top  = (head_addr == {R{1'b1}});
    assign hs           = bus.out_valid & bus.out_ready;
    assign pop          = hs & buf_nonempty;
    assign flush        = abort && (state_q != ST_IDLE);
    // Refill only when the buffer will be empty after this cycle, so a pair never overtakes an older word.
    assign load         = (state_q == ST_FETCH) && !abort &&
                          ((cnt == 2'd0) || ((cnt == 2'd1) && pop));

    regdump_buf #(
        .N (N),
        .R (R)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .load_i      (load),
        .pop_i       (pop),
        .flush_i     (flush),
        .ld_data0_i  (bus.rf_read_data1),
        .ld_addr0_i  (addr1),
        .ld_data1_i  (bus.rf_read_data2),
        .ld_addr1_i  (addr2),
        .count_o     (cnt),
        .head_data_o (head_data),
        .head_addr_o (head_addr)
    );

    always_comb begin
        bus.out_valid = buf_nonempty | in_sum;
        bus.out_data  = '0;
        bus.out_addr  = '0;
        bus.out_last  = 1'b0;
        if (buf_nonempty) begin
            bus.out_data = head_data;
            bus.out_addr = head_addr;
        end
`ifdef REGDUMP_CHECKSUM_EN
        if (in_sum) begin
            bus.out_data = acc_q;
            bus.out_last = 1'b1;
        end
`else
        if (buf_nonempty) begin
            bus.out_last = head_is_top;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        done_d  = 1'b0;
        beats_d = beats_q;
`ifdef REGDUMP_CHECKSUM_EN
        acc_d   = acc_q;
        if (pop) begin
            acc_d = acc_q ^ head_data;
        end
`endif
        if (hs && (state_q != ST_IDLE)) begin
            beats_d = beats_q + BW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d = ST_FETCH;
                    p_d     = '0;
                    beats_d = '0;
`ifdef REGDUMP_CHECKSUM_EN
                    acc_d   = '0;
`endif
                end
            end
            ST_FETCH: begin
                if (load) begin
                    p_d = p_q + PW'(1);
                    if (p_q == P_LAST) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && head_is_top) begin
`ifdef REGDUMP_CHECKSUM_EN
                    state_d = ST_SUM;
`else
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
`endif
                end
            end
`ifdef REGDUMP_CHECKSUM_EN
            ST_SUM: begin
                if (hs) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides everything except the idle state, where it only suppresses start.
        if (flush) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            p_q     <= '0;
            done_q  <= 1'b0;
            beats_q <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            done_q  <= done_d;
            beats_q <= beats_d;
        end
    end

`ifdef REGDUMP_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`endif

    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign dbg_state_o = state_q;
    assign dbg_beats_o = beats_q;

endmodule
